// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared op codes, state encoding and defaults for the HI/LO controller
package hilo_pkg;

    localparam int HILO_DATA_W  = 32;
    localparam int HILO_OP_W    = 6;
    localparam int HILO_MUL_LAT = 6;

    localparam logic [HILO_OP_W-1:0] INSN_MFHI  = 6'h10;
    localparam logic [HILO_OP_W-1:0] INSN_MTHI  = 6'h11;
    localparam logic [HILO_OP_W-1:0] INSN_MFLO  = 6'h12;
    localparam logic [HILO_OP_W-1:0] INSN_MTLO  = 6'h13;
    localparam logic [HILO_OP_W-1:0] INSN_MULT  = 6'h18;
    localparam logic [HILO_OP_W-1:0] INSN_MULTU = 6'h19;

    typedef enum logic {
        HILO_IDLE = 1'b0,
        HILO_BUSY = 1'b1
    } hilo_state_e;

endpackage

// File: rtl/hilo_reg.sv
// rtl/hilo_reg.sv - architectural HI/LO register pair with independent write enables
module hilo_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hi_we,
    input  logic [DATA_W-1:0] hi_wdata,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] lo_wdata,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (hi_we) hi <= hi_wdata;
            if (lo_we) lo <= lo_wdata;
        end
    end

endmodule

// File: rtl/hilo_ctrl.sv
// rtl/hilo_ctrl.sv - multiplier issue, latency watchdog and HI/LO interlock for the EX stage
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int DATA_W  = HILO_DATA_W,
    parameter int OP_W    = HILO_OP_W,
    parameter int MUL_LAT = HILO_MUL_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              req_valid,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_rs,
    input  logic [DATA_W-1:0] req_rt,
    output logic              req_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              mul_ce,
    output logic [DATA_W-1:0] mul_x,
    output logic [DATA_W-1:0] mul_y,
    output logic [OP_W-1:0]   mul_op,
    input  logic              mul_done,
    input  logic [DATA_W-1:0] mul_hi,
    input  logic [DATA_W-1:0] mul_lo,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = $clog2(MUL_LAT + 3);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT + 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    hilo_state_e       state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              rd_valid_nxt, err_nxt;
    logic [DATA_W-1:0] rd_data_nxt;
    logic              hi_we, lo_we;
    logic [DATA_W-1:0] hi_wd, lo_wd;
    logic              op_mul, op_mfhi, op_mflo, op_mthi, op_mtlo, op_mf;

    assign op_mul  = (req_op == OP_W'(INSN_MULT)) || (req_op == OP_W'(INSN_MULTU));
    assign op_mfhi = (req_op == OP_W'(INSN_MFHI));
    assign op_mflo = (req_op == OP_W'(INSN_MFLO));
    assign op_mthi = (req_op == OP_W'(INSN_MTHI));
    assign op_mtlo = (req_op == OP_W'(INSN_MTLO));
    assign op_mf   = op_mfhi || op_mflo;

    assign mul_x  = req_rs;
    assign mul_y  = req_rt;
    assign mul_op = mul_ce ? req_op : '0;
    assign busy   = (state == HILO_BUSY);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        rd_valid_nxt = rd_valid;
        rd_data_nxt  = rd_data;
        err_nxt      = err;
        req_ready    = 1'b0;
        mul_ce       = 1'b0;
        hi_we        = 1'b0;
        lo_we        = 1'b0;
        hi_wd        = req_rs;
        lo_wd        = req_rs;
        // Flush outranks stall so an aborted multiply can never complete later.
        if (reset) begin
            if (flush) begin
                state_nxt    = HILO_IDLE;
                cnt_nxt      = '0;
                rd_valid_nxt = 1'b0;
            end else if (!stall) begin
                rd_valid_nxt = 1'b0;
                case (state)
                    HILO_IDLE: begin
                        if (req_valid) begin
                            req_ready = 1'b1;
                            if (op_mul) begin
                                mul_ce    = 1'b1;
                                cnt_nxt   = CNT_LOAD;
                                state_nxt = HILO_BUSY;
                            end
                            hi_we = op_mthi;
                            lo_we = op_mtlo;
                            if (op_mf) begin
                                rd_valid_nxt = 1'b1;
                                rd_data_nxt  = op_mfhi ? hi : lo;
                            end
                        end
                    end
                    HILO_BUSY: begin
                        if (mul_done) begin
                            hi_we     = 1'b1;
                            lo_we     = 1'b1;
                            hi_wd     = mul_hi;
                            lo_wd     = mul_lo;
                            cnt_nxt   = '0;
                            state_nxt = HILO_IDLE;
                            // Readers in the completion cycle take the product directly.
                            if (req_valid && op_mf) begin
                                req_ready    = 1'b1;
                                rd_valid_nxt = 1'b1;
                                rd_data_nxt  = op_mfhi ? mul_hi : mul_lo;
                            end
                        end else if (cnt == CNT_ONE) begin
                            cnt_nxt   = '0;
                            err_nxt   = 1'b1;
                            state_nxt = HILO_IDLE;
                        end else begin
                            cnt_nxt = cnt - CNT_ONE;
                        end
                    end
                    default: state_nxt = HILO_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= HILO_IDLE;
            cnt      <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rd_valid <= rd_valid_nxt;
            rd_data  <= rd_data_nxt;
            err      <= err_nxt;
        end
    end

    hilo_reg #(.DATA_W(DATA_W)) u_hilo_reg (
        .clk      (clk),
        .reset    (reset),
        .hi_we    (hi_we),
        .hi_wdata (hi_wd),
        .lo_we    (lo_we),
        .lo_wdata (lo_wd),
        .hi       (hi),
        .lo       (lo)
    );

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb/tb_hilo_ctrl.sv - bench for hilo_ctrl with multiplier model and per-cycle reference
module tb_hilo_ctrl;
    import hilo_pkg::*;

    localparam int DW  = 32;
    localparam int OW  = 6;
    localparam int LAT = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          req_valid = 1'b0;
    logic [OW-1:0] req_op = '0;
    logic [DW-1:0] req_rs = '0;
    logic [DW-1:0] req_rt = '0;
    logic          mul_done = 1'b0;
    logic [DW-1:0] mul_hi = '0;
    logic [DW-1:0] mul_lo = '0;
    logic          req_ready, rd_valid, mul_ce, busy, err;
    logic [DW-1:0] rd_data, mul_x, mul_y, hi, lo;
    logic [OW-1:0] mul_op;

    always #5 clk = ~clk;

    hilo_ctrl #(.DATA_W(DW), .OP_W(OW), .MUL_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .req_valid(req_valid), .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt),
        .req_ready(req_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .mul_ce(mul_ce), .mul_x(mul_x), .mul_y(mul_y), .mul_op(mul_op),
        .mul_done(mul_done), .mul_hi(mul_hi), .mul_lo(mul_lo),
        .hi(hi), .lo(lo), .busy(busy), .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_mf(input logic [OW-1:0] op);
        return (op == INSN_MFHI) || (op == INSN_MFLO);
    endfunction

    function automatic bit is_mul(input logic [OW-1:0] op);
        return (op == INSN_MULT) || (op == INSN_MULTU);
    endfunction

    function automatic logic [63:0] product(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic signed [63:0] sa, sb;
        if (op == INSN_MULT) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
        end else begin
            sa = {32'b0, a};
            sb = {32'b0, b};
        end
        return 64'(sa * sb);
    endfunction

    // Reference: architectural view (busy flag, remaining latency budget, HI/LO, read port).
    bit            e_busy = 0, e_err = 0, e_rv = 0;
    int            e_budget = 0;
    logic [DW-1:0] e_hi = '0, e_lo = '0, e_rd = '0;
    logic          exp_rdy, exp_ce;

    assign exp_rdy = reset && !stall && !flush && req_valid &&
                     (!e_busy || (mul_done && is_mf(req_op)));
    assign exp_ce  = exp_rdy && !e_busy && is_mul(req_op);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_busy <= 0; e_err <= 0; e_rv <= 0; e_budget <= 0;
            e_hi <= '0; e_lo <= '0; e_rd <= '0;
        end else if (flush) begin
            e_busy <= 0; e_budget <= 0; e_rv <= 0;
        end else if (!stall) begin
            e_rv <= 0;
            if (exp_rdy) begin
                if (is_mul(req_op)) begin
                    e_busy   <= 1;
                    e_budget <= LAT + 2;
                end
                if (req_op == INSN_MTHI) e_hi <= req_rs;
                if (req_op == INSN_MTLO) e_lo <= req_rs;
                if (is_mf(req_op)) begin
                    e_rv <= 1;
                    if (req_op == INSN_MFHI) e_rd <= e_busy ? mul_hi : e_hi;
                    else                     e_rd <= e_busy ? mul_lo : e_lo;
                end
            end
            if (e_busy) begin
                if (mul_done) begin
                    e_hi <= mul_hi; e_lo <= mul_lo; e_busy <= 0;
                end else if (e_budget == 1) begin
                    e_err <= 1; e_busy <= 0; e_budget <= 0;
                end else begin
                    e_budget <= e_budget - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("mul_ce",    64'(mul_ce),    64'(exp_ce));
        check("mul_op",    64'(mul_op),    exp_ce ? 64'(req_op) : 64'd0);
        check("mul_x",     64'(mul_x),     64'(req_rs));
        check("mul_y",     64'(mul_y),     64'(req_rt));
        check("hi",        64'(hi),        64'(e_hi));
        check("lo",        64'(lo),        64'(e_lo));
        check("rd_valid",  64'(rd_valid),  64'(e_rv));
        check("rd_data",   64'(rd_data),   64'(e_rd));
        check("busy",      64'(busy),      64'(e_busy));
        check("err",       64'(err),       64'(e_err));
    end

    // Multiplier model: LAT unstalled cycles from launch to done, done held through stalls.
    bit          m_in = 0, m_drop = 0;
    int          m_pend = 0;
    logic [63:0] m_prod = '0;

    task automatic step();
        bit ce, st, fl, dn;
        logic [63:0] p;
        @(negedge clk);
        ce = mul_ce; st = stall; fl = flush; dn = mul_done;
        p  = product(req_op, req_rs, req_rt);
        @(posedge clk);
        #1;
        if (m_in && !st) begin
            if (dn) m_in = 0;
            else if (m_pend > 0) m_pend--;
        end
        if (fl) m_in = 0;
        if (ce) begin
            m_in = 1; m_pend = LAT - 1; m_prod = p;
        end
        mul_done = m_in && (m_pend == 0) && !m_drop;
        mul_hi   = mul_done ? m_prod[63:32] : $urandom;
        mul_lo   = mul_done ? m_prod[31:0]  : $urandom;
    endtask

    task automatic drive(input logic v, input logic [OW-1:0] op, input logic [DW-1:0] rs,
                         input logic [DW-1:0] rt);
        req_valid = v; req_op = op; req_rs = rs; req_rt = rt;
    endtask

    logic [OW-1:0] ops [8];
    int busy_cnt, waited;

    initial begin
        ops[0] = INSN_MULT; ops[1] = INSN_MULTU; ops[2] = INSN_MFHI; ops[3] = INSN_MFLO;
        ops[4] = INSN_MTHI; ops[5] = INSN_MTLO;  ops[6] = 6'h00;     ops[7] = 6'h3F;

        step(); step();
        #2;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        step();
        reset = 1'b1;
        step();

        // MULT -1 * 2
        drive(1, INSN_MULT, 32'hFFFFFFFF, 32'd2);
        #2;
        check("t1_ce", 64'(mul_ce), 64'd1);
        check("t1_op", 64'(mul_op), 64'(INSN_MULT));
        step();
        req_valid = 0;
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            #2;
            if (busy) busy_cnt++;
            step();
        end
        check("t1_busy_cycles", 64'(busy_cnt), 64'd6);
        check("t1_hi", 64'(hi), 64'hFFFFFFFF);
        check("t1_lo", 64'(lo), 64'hFFFFFFFE);

        // MFLO two cycles after launch is held off and then forwarded
        drive(1, INSN_MTLO, 32'd0, 32'd0);
        step();
        drive(1, INSN_MULT, 32'hFFFFFFFF, 32'd2);
        step();
        req_valid = 0;
        step();
        drive(1, INSN_MFLO, 32'd0, 32'd0);
        waited = -1;
        for (int i = 0; i < 10; i++) begin
            #2;
            if (req_ready) begin
                waited = i;
                break;
            end
            step();
        end
        check("t2_wait", 64'(waited), 64'd4);
        step();
        req_valid = 0;
        #2;
        check("t2_rd_valid", 64'(rd_valid), 64'd1);
        check("t2_rd_data", 64'(rd_data), 64'hFFFFFFFE);
        step();
        #2;
        check("t2_rd_pulse", 64'(rd_valid), 64'd0);
        step();

        // MULTU with stall over the done cycle (T+6..T+8)
        drive(1, INSN_MULTU, 32'hFFFFFFFF, 32'd2);
        step();
        req_valid = 0;
        for (int i = 0; i < 5; i++) step();
        stall = 1;
        step(); step();
        #2;
        check("t3_hold_hi", 64'(hi), 64'hFFFFFFFF);
        step();
        stall = 0;
        #2;
        check("t3_busy_t9", 64'(busy), 64'd1);
        step();
        #2;
        check("t3_hi", 64'(hi), 64'd1);
        check("t3_lo", 64'(lo), 64'hFFFFFFFE);

        // flush coincident with mul_done
        drive(1, INSN_MTHI, 32'h1234, 32'd0);
        step();
        drive(1, INSN_MTLO, 32'h5678, 32'd0);
        step();
        drive(1, INSN_MULT, 32'd7, 32'd9);
        step();
        req_valid = 0;
        for (int i = 0; i < 5; i++) step();
        flush = 1;
        step();
        flush = 0;
        #2;
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_hi", 64'(hi), 64'h1234);
        check("t4_lo", 64'(lo), 64'h5678);
        step();

        // missing mul_done -> watchdog
        m_drop = 1;
        drive(1, INSN_MULT, 32'd5, 32'd6);
        step();
        req_valid = 0;
        for (int i = 0; i < 7; i++) step();
        #2;
        check("t5_err_early", 64'(err), 64'd0);
        step();
        #2;
        check("t5_err", 64'(err), 64'd1);
        check("t5_idle", 64'(busy), 64'd0);
        check("t5_hi", 64'(hi), 64'h1234);
        m_drop = 0;
        m_in = 0;
        drive(1, INSN_MULT, 32'd5, 32'd6);
        #1;
        check("t5_next_ready", 64'(req_ready), 64'd1);
        step();
        req_valid = 0;
        for (int i = 0; i < 8; i++) step();
        #2;
        check("t5_lo", 64'(lo), 64'd30);
        check("t5_err_sticky", 64'(err), 64'd1);

        // async reset mid-flight
        drive(1, INSN_MULT, 32'd3, 32'd3);
        step();
        step();
        #2;
        reset = 0;
        #1;
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_err", 64'(err), 64'd0);
        check("t6_hi", 64'(hi), 64'd0);
        check("t6_lo", 64'(lo), 64'd0);
        check("t6_ce", 64'(mul_ce), 64'd0);
        check("t6_ready", 64'(req_ready), 64'd0);
        m_in = 0;
        mul_done = 0;
        step();
        step();
        reset = 1;
        drive(1, INSN_MTHI, 32'hA5A5A5A5, 32'd0);
        step();
        drive(1, INSN_MFHI, 32'd0, 32'd0);
        step();
        req_valid = 0;
        #2;
        check("t6_rd_valid", 64'(rd_valid), 64'd1);
        check("t6_rd_data", 64'(rd_data), 64'hA5A5A5A5);
        step();

        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(0, 99) < 12);
            flush = !stall && ($urandom_range(0, 99) < 4);
            drive($urandom_range(0, 99) < 60, ops[$urandom_range(0, 7)], $urandom, $urandom);
            step();
        end
        stall = 0; flush = 0; req_valid = 0;
        for (int i = 0; i < 12; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
